// File: rtl/instr_fetch_stage_pkg.sv
// Purpose: shared fetch/decode definitions (instruction fields, opcodes, fetch FSM states).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: instruction width, field bit positions, HALT opcode, fetch state encoding,
//           and a field-extraction helper used by fetch and the control unit.
package instr_fetch_stage_pkg;

  localparam int IF_INSTR_W = 16;

  // Instruction field bit positions: opcode[15:12] rs[11:8] rt[7:4] rd_imm[3:0]
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int RDI_MSB = 3;
  localparam int RDI_LSB = 0;

  typedef logic [3:0] opcode_t;

  localparam opcode_t IF_HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  function automatic opcode_t get_opcode(input logic [IF_INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// Purpose: program counter register with reset load, +1 increment (wrapping) and redirect load.
// Latency: pc updates on the clock edge after load/inc; pc_nxt is the combinational next value.
// Backpressure: none; the caller decides when to load or increment.
// Ports: clk, rst_n (async active-low), load/load_pc (redirect), inc (advance), pc, pc_nxt.
module instr_fetch_stage_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt
);

  // Redirect wins over increment; natural overflow gives the wrap to 0.
  always_comb begin
    pc_nxt = pc;
    if (load) begin
      pc_nxt = load_pc;
    end else if (inc) begin
      pc_nxt = pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Purpose: instruction fetch stage; issues imem word requests, holds the fetched instruction for decode.
// Latency: >=1 cycle from request to IR capture, one instruction at most every 2 cycles.
// Backpressure: id_ready=0 holds id_valid and IR stable indefinitely; no new fetch until consumed.
// Ports: clk, rst_n; imem_req/imem_addr/imem_ack/imem_rdata (memory); id_valid/id_ready/id_opcode/
//        id_rs/id_rt/id_rd_imm/id_pc (decode); redirect_valid/redirect_pc; halted.
// Option: FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = IF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = IF_HALT_OP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [3:0]         id_opcode,
  output logic [3:0]         id_rs,
  output logic [3:0]         id_rt,
  output logic [3:0]         id_rd_imm,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  fetch_state_t       state, state_nxt;
  logic               kill, kill_nxt;
  logic               pc_load, pc_inc, ir_load, addr_load;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] ir;

  instr_fetch_stage_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_nxt  (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    addr_load = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        pc_load   = redirect_valid;
        addr_load = 1'b1;
      end
      S_REQ: begin
        if (redirect_valid) begin
          // The request stays up; its data is dropped when it finally returns.
          pc_load = 1'b1;
          if (imem_ack) begin
            kill_nxt  = 1'b0;
            addr_load = 1'b1;
          end else begin
            kill_nxt  = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill) begin
            // Stale return for a pre-redirect address: re-issue at the redirected pc.
            kill_nxt  = 1'b0;
            addr_load = 1'b1;
          end else begin
            ir_load   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect squashes the held instruction and also suppresses a same-cycle HALT.
        if (redirect_valid) begin
          pc_load   = 1'b1;
          addr_load = 1'b1;
          state_nxt = S_REQ;
        end else if (id_ready) begin
          if (get_opcode(ir[IF_INSTR_W-1:0]) == HALT_OP) begin
            state_nxt = S_HALT;
          end else begin
            addr_load = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kill      <= 1'b0;
      ir        <= '0;
      id_pc     <= '0;
      imem_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (ir_load) begin
        ir    <= imem_rdata;
        id_pc <= pc;
      end
      // imem_addr only moves when a new request starts, so it is stable until ack.
      if (addr_load) begin
        imem_addr <= pc_nxt;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign id_valid  = (state == S_HOLD);
  assign halted    = (state == S_HALT);
  assign id_opcode = ir[OPC_MSB:OPC_LSB];
  assign id_rs     = ir[RS_MSB:RS_LSB];
  assign id_rt     = ir[RT_MSB:RT_LSB];
  assign id_rd_imm = ir[RDI_MSB:RDI_LSB];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (ir_load && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if ((state == S_HOLD) && !id_ready && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Purpose: self-checking bench for instr_fetch_stage with a memory model, scoreboard and monitor.
// Latency: n/a.
// Backpressure: bench drives random/directed id_ready and memory ack latency.
module tb_instr_fetch_stage;

  localparam int          ADDR_W   = 8;
  localparam int          INSTR_W  = 16;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic               clk;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic               id_ready;
  logic [3:0]         id_opcode, id_rs, id_rt, id_rd_imm;
  logic [ADDR_W-1:0]  id_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        perf_fetched, perf_stall;
`endif

  instr_fetch_stage #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC),
    .HALT_OP  (4'b1111)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_opcode      (id_opcode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd_imm      (id_rd_imm),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents and the architectural reference model.
  logic [15:0] mem [256];
  logic [23:0] exp_q [$];   // {pc, instruction} expected at each decode handshake
  logic [7:0]  model_pc;
  bit          halted_m;
  int          fetched_m, stall_m;

  // Memory responder state.
  bit          pend, pkill;
  int          plat;
  logic [7:0]  paddr;
  int          lat_cfg;

  wire [15:0] id_word = {id_opcode, id_rs, id_rt, id_rd_imm};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem();
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h7;
      mem[i] = w;
    end
  endtask

  // One clock cycle: memory response, decode/redirect inputs, model update.
  // Entered and left at posedge+2.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] rpc);
    bit hs;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (imem_req) begin
      if (!pend) begin
        pend  = 1'b1;
        pkill = 1'b0;
        paddr = imem_addr;
        plat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
        chk("imem_addr_hold", imem_addr, paddr);
      end
      if (plat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[paddr];
        pend       = 1'b0;
        if (!pkill && !rv) fetched_m++;
      end else begin
        plat--;
        if (rv) pkill = 1'b1;
      end
    end else begin
      pend = 1'b0;
    end

    hs = id_valid && rdy;
    if (id_valid && !rdy && stall_m < 65535) stall_m++;
    if (!halted_m) begin
      if (hs) begin
        exp_q.push_back({model_pc, mem[model_pc]});
        if (!rv && mem[model_pc][15:12] == 4'hF) halted_m = 1'b1;
        model_pc = model_pc + 8'd1;
      end
      if (rv) model_pc = rpc;
    end

    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    pend           = 1'b0;
    exp_q.delete();
    model_pc       = RESET_PC;
    halted_m       = 1'b0;
    fetched_m      = 0;
    stall_m        = 0;
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_fields", id_word, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pop on every decode handshake plus hold/throughput protocol checks.
  bit          prev_v, prev_rdy, prev_rv;
  logic [15:0] prev_word;
  logic [23:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_rdy && !prev_rv) begin
        chk("hold_valid", id_valid, 1);
        chk("hold_ir", id_word, prev_word);
      end
      chk("no_req_while_valid", imem_req && id_valid, 0);
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %0h instr %0h expected no handshake", id_pc, id_word);
        end else begin
          e = exp_q.pop_front();
          chk("sb_id_pc", id_pc, e[23:16]);
          chk("sb_id_instr", id_word, e[15:0]);
        end
      end
      prev_v    = id_valid;
      prev_rdy  = id_ready;
      prev_rv   = redirect_valid;
      prev_word = id_word;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat_cfg        = 0;
    fill_mem();
    mem[0] = 16'h1234;
    #3;

    // Basic fetch with 1-cycle memory.
    do_reset();
    chk("idle_no_req", imem_req, 0);
    step(1, 0, 8'h00);
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 8'h00);
    step(1, 0, 8'h00);
    chk("t1_valid", id_valid, 1);
    chk("t1_opcode", id_opcode, 4'h1);
    chk("t1_rs", id_rs, 4'h2);
    chk("t1_rt", id_rt, 4'h3);
    chk("t1_rd_imm", id_rd_imm, 4'h4);
    chk("t1_id_pc", id_pc, 8'h00);
    chk("t1_no_req_hold", imem_req, 0);
    step(1, 0, 8'h00);
    chk("t1_next_req", imem_req, 1);
    chk("t1_next_addr", imem_addr, 8'h01);

    // 3-cycle ack delay, then 4 cycles of decode backpressure.
    lat_cfg = 3;
    n = 0;
    while (!id_valid && n < 10) begin
      chk("t2_addr_held", imem_addr, 8'h01);
      step(0, 0, 8'h00);
      n++;
    end
    chk("t2_ack_cycles", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_bp_valid", id_valid, 1);
      chk("t2_bp_noreq", imem_req, 0);
      chk("t2_bp_ir", id_word, mem[1]);
      step(0, 0, 8'h00);
    end
    step(1, 0, 8'h00);
    chk("t2_next_addr", imem_addr, 8'h02);

    // Redirect before ack: killed data must never reach decode.
    mem[2]    = 16'hAAAA;
    mem[8'h40] = 16'h5678;
    lat_cfg   = 2;
    step(1, 1, 8'h40);
    n = 0;
    while (imem_addr != 8'h40 && n < 8) begin
      chk("t3_no_valid", id_valid, 0);
      step(1, 0, 8'h00);
      n++;
    end
    chk("t3_redirect_addr", imem_addr, 8'h40);
    chk("t3_req", imem_req, 1);
    lat_cfg = 0;
    step(0, 0, 8'h00);
    chk("t3_valid", id_valid, 1);
    chk("t3_id_pc", id_pc, 8'h40);
    chk("t3_instr", id_word, 16'h5678);

    // Redirect in S_HOLD together with handshake.
    step(1, 1, 8'h10);
    chk("t4_valid_drop", id_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 8'h10);

    // HALT at address 5 (reached via redirect coinciding with an ack).
    mem[5] = 16'hF000;
    step(0, 1, 8'h05);
    chk("t5_addr", imem_addr, 8'h05);
    step(1, 0, 8'h00);
    chk("t5_halt_op", id_opcode, 4'hF);
    step(1, 0, 8'h00);
    chk("t5_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      chk("t5_halt_noreq", imem_req, 0);
      chk("t5_halt_novalid", id_valid, 0);
      chk("t5_halt_stays", halted, 1);
      step(0, (i == 7), 8'h33);
    end
    do_reset();
    chk("t5_restart_halted", halted, 0);
    step(1, 0, 8'h00);
    chk("t5_restart_req", imem_req, 1);
    chk("t5_restart_addr", imem_addr, RESET_PC);

    // PC wrap 0xFF -> 0x00.
    step(0, 1, 8'hFF);
    chk("t6_addr_ff", imem_addr, 8'hFF);
    step(1, 0, 8'h00);
    chk("t6_id_pc_ff", id_pc, 8'hFF);
    step(1, 0, 8'h00);
    chk("t6_wrap_addr", imem_addr, 8'h00);

    // Three fetches with 2+1+1 stall cycles after a fresh reset.
    do_reset();
    step(1, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 8'h00);
      for (int s = 0; s < ((k == 0) ? 2 : 1); s++) step(0, 0, 8'h00);
      step(1, 0, 8'h00);
    end
    chk("t7_model_fetched", fetched_m, 3);
    chk("t7_model_stall", stall_m, 4);
`ifdef FETCH_PERF_CNT_EN
    chk("t7_perf_fetched", perf_fetched, 16'd3);
    chk("t7_perf_stall", perf_stall, 16'd4);
`endif

    // Randomized traffic against the reference model.
    fill_mem();
    do_reset();
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 8'($urandom));
    end
    chk("rand_sb_drained", exp_q.size(), 0);
    chk("rand_not_halted", halted, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rand_perf_fetched", perf_fetched, fetched_m);
    chk("rand_perf_stall", perf_stall, stall_m);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
